// File: rtl/id_ex_stage.sv
// Decode/Execute pipeline register with destination resolution, load-use
// bubble insertion, downstream hold/flush handling and saturating event counters.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int IMM_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [IMM_W-1:0]  id_imm,
  input  logic              id_dm_write,
  input  logic              id_rf_dest_addr,
  input  logic              id_rf_write,
  input  logic              id_sli_sri,
  input  logic              id_imm_instr,
  input  logic [1:0]        id_jump_or_branch,
  input  logic [1:0]        id_mem_to_reg,
  input  logic              mem_hold_i,
  input  logic              flush_i,
  output logic              id_stall_o,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [IMM_W-1:0]  ex_imm,
  output logic              ex_dm_write,
  output logic              ex_rf_write,
  output logic              ex_sli_sri,
  output logic              ex_imm_instr,
  output logic [1:0]        ex_jump_or_branch,
  output logic [1:0]        ex_mem_to_reg,
  output logic [REG_AW-1:0] ex_wr_addr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [IMM_W-1:0]  imm;
    logic              dm_write;
    logic              rf_write;
    logic              sli_sri;
    logic              imm_instr;
    logic [1:0]        jump_or_branch;
    logic [1:0]        mem_to_reg;
    logic [REG_AW-1:0] wr_addr;
  } ex_t;

  ex_t              ex_q;
  ex_t              id_next;
  logic [REG_AW-1:0] wr_sel;
  logic             uses_rt;
  logic             load_use;

  assign wr_sel  = id_rf_dest_addr ? id_rd_addr : id_rt_addr;
  assign uses_rt = ~id_imm_instr & ~id_sli_sri & (id_mem_to_reg == 2'b00);

  assign load_use = ex_q.valid & ex_q.rf_write & (ex_q.mem_to_reg == 2'b01)
                  & (ex_q.wr_addr != '0) & id_valid
                  & ((ex_q.wr_addr == id_rs_addr) | (uses_rt & (ex_q.wr_addr == id_rt_addr)));

  assign id_stall_o = ~flush_i & (mem_hold_i | load_use);

  // Controls are gated by id_valid so a NOP can never write RF/DM or redirect.
  always_comb begin
    id_next                = '0;
    id_next.valid          = id_valid;
    id_next.pc             = id_pc;
    id_next.rs_data        = id_rs_data;
    id_next.rt_data        = id_rt_data;
    id_next.imm            = id_imm;
    id_next.wr_addr        = wr_sel;
    id_next.dm_write       = id_valid & id_dm_write;
    id_next.rf_write       = id_valid & id_rf_write;
    id_next.sli_sri        = id_valid & id_sli_sri;
    id_next.imm_instr      = id_valid & id_imm_instr;
    id_next.jump_or_branch = id_valid ? id_jump_or_branch : 2'b00;
    id_next.mem_to_reg     = id_valid ? id_mem_to_reg : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (flush_i) begin
      ex_q <= '0;
      if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end else if (mem_hold_i) begin
      ex_q <= ex_q;
    end else if (load_use) begin
      ex_q <= '0;
      if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end else begin
      ex_q <= id_next;
    end
  end

  assign ex_valid          = ex_q.valid;
  assign ex_pc             = ex_q.pc;
  assign ex_rs_data        = ex_q.rs_data;
  assign ex_rt_data        = ex_q.rt_data;
  assign ex_imm            = ex_q.imm;
  assign ex_dm_write       = ex_q.dm_write;
  assign ex_rf_write       = ex_q.rf_write;
  assign ex_sli_sri        = ex_q.sli_sri;
  assign ex_imm_instr      = ex_q.imm_instr;
  assign ex_jump_or_branch = ex_q.jump_or_branch;
  assign ex_mem_to_reg     = ex_q.mem_to_reg;
  assign ex_wr_addr        = ex_q.wr_addr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, latching, load-use stalls, hold,
// flush priority, NOP gating and counter saturation.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs_data, id_rt_data;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [15:0] id_imm;
  logic        id_dm_write, id_rf_dest_addr, id_rf_write, id_sli_sri, id_imm_instr;
  logic [1:0]  id_jump_or_branch, id_mem_to_reg;
  logic        mem_hold_i, flush_i;
  logic        id_stall_o;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data;
  logic [15:0] ex_imm;
  logic        ex_dm_write, ex_rf_write, ex_sli_sri, ex_imm_instr;
  logic [1:0]  ex_jump_or_branch, ex_mem_to_reg;
  logic [4:0]  ex_wr_addr;
  logic [15:0] stall_cnt, flush_cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .IMM_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_imm(id_imm), .id_dm_write(id_dm_write), .id_rf_dest_addr(id_rf_dest_addr),
    .id_rf_write(id_rf_write), .id_sli_sri(id_sli_sri), .id_imm_instr(id_imm_instr),
    .id_jump_or_branch(id_jump_or_branch), .id_mem_to_reg(id_mem_to_reg),
    .mem_hold_i(mem_hold_i), .flush_i(flush_i), .id_stall_o(id_stall_o),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_dm_write(ex_dm_write), .ex_rf_write(ex_rf_write),
    .ex_sli_sri(ex_sli_sri), .ex_imm_instr(ex_imm_instr),
    .ex_jump_or_branch(ex_jump_or_branch), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_wr_addr(ex_wr_addr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one Decode instruction; data fields derived from pc for traceability.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                       input logic dmw, input logic dest, input logic rfw, input logic sli,
                       input logic immi, input logic [1:0] jb, input logic [1:0] m2r);
    id_valid = v; id_pc = pc; id_rs_data = pc ^ 32'h1111_1111; id_rt_data = pc ^ 32'h2222_2222;
    id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd; id_imm = imm;
    id_dm_write = dmw; id_rf_dest_addr = dest; id_rf_write = rfw; id_sli_sri = sli;
    id_imm_instr = immi; id_jump_or_branch = jb; id_mem_to_reg = m2r;
  endtask

  task automatic nop();
    drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic load(input logic [31:0] pc, input logic [4:0] rt);
    drive(1'b1, pc, 5'd1, rt, 5'd0, 16'h0004, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b01);
  endtask

  task automatic alu(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd);
    drive(1'b1, pc, rs, rt, rd, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  initial begin
    rst_n = 1'b0; mem_hold_i = 1'b0; flush_i = 1'b0;
    nop();
    #2;
    check("rst_valid", ex_valid, 0);
    check("rst_stall", id_stall_o, 0);
    #10 rst_n = 1'b1;

    // Reset mid-stream: one flush so the counter is nonzero, then an ADD, then reset.
    flush_i = 1'b1; step(); flush_i = 1'b0;
    check("pre_rst_flush_cnt", flush_cnt, 1);
    alu(32'h40, 5'd1, 5'd2, 5'd3); step();
    check("pre_rst_valid", ex_valid, 1);
    #2 rst_n = 1'b0; #1;
    check("midrst_valid", ex_valid, 0);
    check("midrst_wr_addr", ex_wr_addr, 0);
    check("midrst_rf_write", ex_rf_write, 0);
    check("midrst_pc", ex_pc, 0);
    check("midrst_flush_cnt", flush_cnt, 0);
    check("midrst_stall_cnt", stall_cnt, 0);
    #1 rst_n = 1'b1;

    // Normal ADD r3 = r1 + r2.
    alu(32'h100, 5'd1, 5'd2, 5'd3); #1;
    check("add_stall", id_stall_o, 0);
    step();
    check("add_valid", ex_valid, 1);
    check("add_wr_addr", ex_wr_addr, 3);
    check("add_rf_write", ex_rf_write, 1);
    check("add_pc", ex_pc, 32'h100);
    check("add_rs_data", ex_rs_data, 32'h1111_1011);
    check("add_rt_data", ex_rt_data, 32'h2222_2322);

    // Load-use on rs.
    load(32'h104, 5'd5); step();
    check("ld5_wr_addr", ex_wr_addr, 5);
    check("ld5_m2r", ex_mem_to_reg, 2'b01);
    alu(32'h108, 5'd5, 5'd6, 5'd8); #1;
    check("lu_stall", id_stall_o, 1);
    step();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_pc", ex_pc, 0);
    check("lu_stall_cnt", stall_cnt, 1);
    check("lu_stall_clear", id_stall_o, 0);
    step();
    check("lu_add_valid", ex_valid, 1);
    check("lu_add_wr", ex_wr_addr, 8);
    check("lu_add_pc", ex_pc, 32'h108);

    // Load to r0 never stalls.
    load(32'h10c, 5'd0); step();
    alu(32'h110, 5'd0, 5'd2, 5'd9); #1;
    check("ld0_stall", id_stall_o, 0);
    step();
    check("ld0_add_wr", ex_wr_addr, 9);
    check("ld0_stall_cnt", stall_cnt, 1);

    // Load r7 then ADDI reading rt=7 as destination: no stall.
    load(32'h114, 5'd7); step();
    drive(1'b1, 32'h118, 5'd1, 5'd7, 5'd0, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
    #1;
    check("addi_stall", id_stall_o, 0);
    step();
    check("addi_valid", ex_valid, 1);
    check("addi_imm_instr", ex_imm_instr, 1);
    check("addi_imm", ex_imm, 16'h0010);
    check("addi_wr", ex_wr_addr, 7);

    // Load r7 then store reading rt=7: stall.
    load(32'h11c, 5'd7); step();
    drive(1'b1, 32'h120, 5'd1, 5'd7, 5'd0, 16'h0008, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    #1;
    check("sw_stall", id_stall_o, 1);
    step();
    check("sw_bubble", ex_valid, 0);
    check("sw_stall_cnt", stall_cnt, 2);
    step();
    check("sw_dm_write", ex_dm_write, 1);
    check("sw_pc", ex_pc, 32'h120);

    // Hold with SUB in EX for three edges.
    alu(32'h200, 5'd2, 5'd3, 5'd4); step();
    alu(32'h204, 5'd5, 5'd6, 5'd10); mem_hold_i = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      check("hold_stall", id_stall_o, 1);
      step();
      check("hold_pc", ex_pc, 32'h200);
      check("hold_wr", ex_wr_addr, 4);
    end
    mem_hold_i = 1'b0; step();
    check("hold_next_pc", ex_pc, 32'h204);
    check("hold_next_wr", ex_wr_addr, 10);
    check("hold_stall_cnt", stall_cnt, 2);

    // Flush beats hold and load-use.
    load(32'h208, 5'd5); step();
    alu(32'h20c, 5'd5, 5'd6, 5'd8); mem_hold_i = 1'b1; flush_i = 1'b1; #1;
    check("flush_stall", id_stall_o, 0);
    step();
    check("flush_valid", ex_valid, 0);
    check("flush_rf_write", ex_rf_write, 0);
    check("flush_cnt1", flush_cnt, 1);
    check("flush_stall_cnt", stall_cnt, 2);
    mem_hold_i = 1'b0; flush_i = 1'b0;

    // NOP with stray controls: all controls forced low.
    drive(1'b0, 32'h300, 5'd1, 5'd2, 5'd3, 16'h00ff, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 2'b10);
    step();
    check("nop_valid", ex_valid, 0);
    check("nop_rf_write", ex_rf_write, 0);
    check("nop_dm_write", ex_dm_write, 0);
    check("nop_jb", ex_jump_or_branch, 0);
    check("nop_m2r", ex_mem_to_reg, 0);
    check("nop_pc", ex_pc, 32'h300);

    // Flush counter saturation: bring to 0xFFFE then three more flushes.
    nop(); flush_i = 1'b1;
    repeat (65533) step();
    check("sat_pre", flush_cnt, 16'hFFFE);
    repeat (3) step();
    check("sat_flush_cnt", flush_cnt, 16'hFFFF);
    flush_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between Decode and Execute in the 5-stage core.
- Latches register-file operands, immediate, PC and the decoded control bundle from the control unit: DM_write, RF_dest_addr, RF_write, sli_sri, imm_instr, jump_or_branch, mem_to_reg.
- Resolves the write-back destination register.
- Detects load-use hazards, stalls Fetch/Decode and inserts bubbles.
- Honours downstream hold and branch/jump flush; keeps saturating stall and flush counters.

Parameters:
DATA_W, 32, operand/PC width
REG_AW, 5, register address width
IMM_W, 16, immediate width
CNT_W, 16, performance counter width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  Decode holds a real instruction
id_pc  in  DATA_W  PC of decode instruction
id_rs_data  in  DATA_W  register file read port A
id_rt_data  in  DATA_W  register file read port B
id_rs_addr  in  REG_AW  source register rs
id_rt_addr  in  REG_AW  register rt
id_rd_addr  in  REG_AW  register rd
id_imm  in  IMM_W  immediate field
id_dm_write, id_rf_dest_addr, id_rf_write, id_sli_sri, id_imm_instr  in  1 each  control unit outputs
id_jump_or_branch  in  2  control unit output
id_mem_to_reg  in  2  control unit output
mem_hold_i  in  1  downstream stage cannot accept; freeze EX
flush_i  in  1  taken jump/branch resolved downstream; kill EX and Decode
id_stall_o  out  1  hold PC and IF/ID register this cycle
ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm  out  1/DATA_W/DATA_W/DATA_W/IMM_W  registered datapath fields
ex_dm_write, ex_rf_write, ex_sli_sri, ex_imm_instr  out  1 each  registered controls
ex_jump_or_branch, ex_mem_to_reg  out  2 each  registered controls
ex_wr_addr  out  REG_AW  resolved destination register
stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Reset (rst_n low, asynchronous):
  - All ex_* outputs are 0, so EX holds a bubble.
  - Both counters are 0.
  - id_stall_o is 0; it is combinational and evaluates to 0 with EX empty and no hold.
- Destination: wr_sel = id_rd_addr when id_rf_dest_addr=1, else id_rt_addr. This value is latched into ex_wr_addr.
- uses_rt = ~id_imm_instr & ~id_sli_sri & (id_mem_to_reg==2'b00). Stores, ALU ops and branches read rt. Loads, moves, shifts and immediates do not.
- load_use (combinational) is 1 only when all of the following hold:
  - ex_valid=1, ex_rf_write=1 and ex_mem_to_reg==2'b01;
  - ex_wr_addr != 0;
  - id_valid=1;
  - ex_wr_addr==id_rs_addr, or (uses_rt and ex_wr_addr==id_rt_addr).
- id_stall_o = ~flush_i & (mem_hold_i | load_use). This is combinational, same cycle.
- Per-edge update, highest priority first:
  1. flush_i=1: EX loads a bubble (all ex_* = 0), regardless of hold or load_use. flush_cnt increments.
  2. mem_hold_i=1: all ex_* hold their values and the counters hold.
  3. load_use=1: EX loads a bubble. stall_cnt increments. The Decode instruction is re-presented next cycle; the load has moved on, so the hazard clears after exactly 1 bubble.
  4. Otherwise: every ex_* field takes its id_* counterpart; ex_valid=id_valid and ex_wr_addr=wr_sel.
- If id_valid=0, case 4 still latches. All control fields are forced to 0, so a NOP never writes RF or DM and never redirects.
- Latency: 1 cycle from Decode to EX outputs.
- A bubble clears every field, including data, so output values are deterministic.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-stall or mid-hold clears state immediately. The first edge after release behaves per the priority list.

Test Plan:
- Reset mid-stream: drive a valid ADD, then pull rst_n low between edges → all ex_* = 0 immediately; stall_cnt=flush_cnt=0.
- Normal ADD: rs=1, rt=2, rd=3, rf_dest_addr=1, rf_write=1 → next edge ex_wr_addr=3, ex_rf_write=1, ex_valid=1, id_stall_o=0.
- Load-use: EX holds LOAD with ex_wr_addr=5 (mem_to_reg=01); Decode holds ADD with rs=5 → id_stall_o=1 that cycle. Next edge: ex_valid=0 and stall_cnt=1. Following edge: ADD enters EX.
- Loads that must not stall:
  - LOAD to r0 followed by ADD with rs=0 → no stall.
  - LOAD to r7 followed by ADDI with rt=7 (uses_rt=0) → no stall.
- Hold: mem_hold_i=1 for 3 cycles with SUB in EX → ex_* unchanged and id_stall_o=1 for those 3 cycles; SUB's successor enters on the 4th edge.
- Flush priority: flush_i=1 together with mem_hold_i=1 and load_use → id_stall_o=0; EX becomes a bubble and flush_cnt increments.
- Saturation: preload flush_cnt to 0xFFFE, then pulse flush_i 3 times → flush_cnt ends at 0xFFFF.
